// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: latches an operand pair, ripples one full-adder cell
// across it LSB first (one bit per clock), then holds {carry_out, sum} until accepted.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             c_q,     c_d;
    logic             cout_q,  cout_d;
    logic [1:0]       fa;

    // Two half-adder stages and a carry OR; returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic p, g1, s, g2;
        p  = x ^ y;
        g1 = x & y;
        s  = p ^ ci;
        g2 = p & ci;
        return {g1 | g2, s};
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        fa      = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = 1'b0;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                fa            = full_add(a_q[idx_q], b_q[idx_q], c_q);
                sum_d[idx_q]  = fa[0];
                c_d           = fa[1];
                if (idx_q == LAST_IDX) begin
                    cout_d  = fa[1];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset clears the datapath too so an aborted add never leaves a partial sum visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == ADD);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: the driver pushes expected {carry,sum} on each
// accepted operand pair; a negedge monitor pops and compares on every output handshake.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         busy;

    int tests = 0;
    int fails = 0;
    logic [W:0] sb[$];
    bit rnd_ready = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a result is consumed at the next posedge whenever both sides are high here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got %0d, expected none", {carry_out, sum});
            end else begin
                logic [W:0] e;
                e = sb.pop_front();
                if ({carry_out, sum} !== e) begin
                    fails++;
                    $display("FAIL result: got %0d, expected %0d at %0t", {carry_out, sum}, e, $time);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present a pair, hold in_valid until the controller is ready, push the expectation at the accept edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        a = x;
        b = y;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready got 0, expected 1");
        end
        @(posedge clk);
        sb.push_back({1'b0, x} + {1'b0, y});
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    initial begin
        logic [W-1:0] s0;
        logic         c0;
        bit           seen;
        int           n;
        logic [W-1:0] ra, rb;

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_carry", 32'(carry_out), 32'd0);

        // 3 + 5 and exact latency of 8 cycles
        send(8'd3, 8'd5);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) chk("busy_in_add", 32'(busy), 32'd1);
            chk($sformatf("latency_k%0d", k), 32'(out_valid), (k == W) ? 32'd1 : 32'd0);
        end

        // Overflow
        send(8'd255, 8'd1);
        send(8'd255, 8'd255);
        wait_valid("ovf_valid");

        // Backpressure: 100 + 200 = 300 -> sum 44, carry 1
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'd100, 8'd200);
        wait_valid("bp_valid");
        chk("bp_sum", 32'(sum), 32'd44);
        chk("bp_carry", 32'(carry_out), 32'd1);
        s0 = sum;
        c0 = carry_out;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sum", 32'(sum), 32'(s0));
            chk("bp_hold_carry", 32'(carry_out), 32'(c0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        // New operands offered during ADD are ignored until IDLE
        send(8'd7, 8'd9);
        a = 8'd10;
        b = 8'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("ovl_in_ready", 32'(in_ready), 32'd0);
        send(8'd10, 8'd20);
        wait_valid("ovl_valid");
        chk("ovl_sum", 32'(sum), 32'd30);

        // Reset at idx=4 aborts without a result
        @(posedge clk);
        #1;
        send(8'd15, 8'd27);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_carry", 32'(carry_out), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);

        // Random stream with random backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            send(ra, rb);
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stream_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
